// File: rtl/tensor_slice_pkg.sv
// Shared types and helpers for the parametrised tensor slice.
package tensor_slice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Width used when classifying an accumulator against the output range.
    localparam int SAT_W = 64;

    // Result of comparing a wide accumulator against a signed OW-bit range.
    typedef struct packed {
        logic above;    // acc > 2^(ow-1)-1
        logic below;    // acc < -2^(ow-1)
    } ow_range_t;

    // Accumulator width that cannot overflow for an N-term dot product of DW-bit operands.
    function automatic int acc_width(input int n, input int dw);
        return 2 * dw + $clog2(n) + 1;
    endfunction

    // Classifies acc against the signed ow-bit range; the caller picks the clamp
    // constant or the truncated bits and raises overflow when either flag is set.
    function automatic ow_range_t sat_to_ow(input logic signed [SAT_W-1:0] acc, input int ow);
        ow_range_t r;
        logic signed [SAT_W-1:0] hi;
        hi      = (64'sd1 <<< (ow - 1)) - 64'sd1;
        r.above = (acc > hi);
        r.below = (acc < (-hi - 64'sd1));
        return r;
    endfunction

endpackage

// File: rtl/chain_delay_line.sv
// Fixed-depth shift register that carries a chain bus between tiled slices.
module chain_delay_line #(
    parameter int W     = 64,
    parameter int DEPTH = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] i_data,
    output logic [W-1:0] o_data
);

    logic [W-1:0] r_stage [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage samples the chain input every cycle.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) r_stage[gi] <= '0;
                    else       r_stage[gi] <= i_data;
                end
            end else begin : g_rest
                // Later stages shift the previous stage forward.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) r_stage[gi] <= '0;
                    else       r_stage[gi] <= r_stage[gi-1];
                end
            end
        end
    endgenerate

    assign o_data = r_stage[DEPTH-1];

endmodule

// File: rtl/tensor_slice_param.sv
// Behavioural N x N tensor slice: load A/B tiles, compute C = A*B (or C += A*B),
// drain C row by row under valid/ready, and pass A/B chain buses through delay lines.
module tensor_slice_param
    import tensor_slice_pkg::*;
#(
    parameter int N           = 8,
    parameter int DW          = 8,
    parameter int OW          = 16,
    parameter int ACCW        = acc_width(N, DW),
    parameter int COMPUTE_LAT = 16,
    parameter int CHAIN_DEPTH = 33
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            accumulate,
    input  logic            saturate,
    input  logic            ld_valid,
    input  logic [N*DW-1:0] a_data,
    input  logic [N*DW-1:0] b_data,
    input  logic [N*DW-1:0] a_data_in,
    input  logic [N*DW-1:0] b_data_in,
    output logic [N*DW-1:0] a_data_out,
    output logic [N*DW-1:0] b_data_out,
    output logic            busy,
    output logic            c_valid,
    input  logic            c_ready,
    output logic [N*OW-1:0] c_data_out,
    output logic            c_last,
    output logic            done,
    output logic            overflow
);

    localparam int RW = $clog2(N);
    localparam int CW = $clog2(COMPUTE_LAT + 1);
    localparam logic [OW-1:0] OW_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] OW_MIN = {1'b1, {(OW-1){1'b0}}};

    state_t            r_state;
    state_t            w_state_next;
    logic [CW-1:0]     r_cnt;          // load beat, then compute cycle
    logic [RW-1:0]     r_row;          // drain row pointer
    logic              r_acc_mode;
    logic              r_sat_mode;
    logic              r_overflow;
    logic              r_done;
    logic [N*DW-1:0]   r_a [N];        // r_a[i] = row i of A
    logic [N*DW-1:0]   r_b [N];        // r_b[j] = column j of B
    logic [OW-1:0]     r_c [N][N];     // held C, persists across ops

    logic [RW-1:0]     w_row_idx;
    logic              w_compute_row;
    logic              w_handshake;
    logic signed [ACCW-1:0] w_acc [N];
    ow_range_t         w_rng [N];
    logic [OW-1:0]     w_val [N];
    logic [N-1:0]      w_ovf;

    assign w_row_idx     = r_cnt[RW-1:0];
    assign w_compute_row = (r_cnt < CW'(N));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = LOAD;
            LOAD:    if (ld_valid && r_cnt == CW'(N - 1)) w_state_next = COMPUTE;
            COMPUTE: if (r_cnt == CW'(COMPUTE_LAT - 1)) w_state_next = DRAIN;
            DRAIN:   if (c_ready && r_row == RW'(N - 1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        busy        = (r_state != IDLE);
        c_valid     = (r_state == DRAIN);
        c_last      = (r_state == DRAIN) && (r_row == RW'(N - 1));
        w_handshake = (r_state == DRAIN) && c_ready;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_col
            // Dot product of the current A row with column gi of B, plus held C when accumulating.
            always_comb begin
                logic signed [2*DW-1:0] v_prod;
                v_prod     = '0;
                w_acc[gi]  = '0;
                for (int k = 0; k < N; k++) begin
                    v_prod    = $signed(r_a[w_row_idx][k*DW +: DW]) * $signed(r_b[gi][k*DW +: DW]);
                    w_acc[gi] = w_acc[gi] + {{(ACCW-2*DW){v_prod[2*DW-1]}}, v_prod};
                end
                if (r_acc_mode) begin
                    w_acc[gi] = w_acc[gi] + {{(ACCW-OW){r_c[w_row_idx][gi][OW-1]}}, r_c[w_row_idx][gi]};
                end
            end

            assign w_rng[gi] = sat_to_ow({{(SAT_W-ACCW){w_acc[gi][ACCW-1]}}, w_acc[gi]}, OW);
            assign w_ovf[gi] = w_rng[gi].above | w_rng[gi].below;

            // Clamp or truncate the accumulator to the stored/output width.
            always_comb begin
                w_val[gi] = w_acc[gi][OW-1:0];
                if (r_sat_mode && w_rng[gi].above)      w_val[gi] = OW_MAX;
                else if (r_sat_mode && w_rng[gi].below) w_val[gi] = OW_MIN;
            end

            // Drain mux: lane gi of the current row, zero when no row is offered.
            assign c_data_out[gi*OW +: OW] = c_valid ? r_c[r_row][gi] : '0;
        end
    endgenerate

    // Datapath: mode latch, tile capture, row compute, drain pointer and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt      <= '0;
            r_row      <= '0;
            r_acc_mode <= 1'b0;
            r_sat_mode <= 1'b0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                for (int j = 0; j < N; j++) r_c[i][j] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc_mode <= accumulate;
                        r_sat_mode <= saturate;
                        r_overflow <= 1'b0;
                        r_cnt      <= '0;
                        r_row      <= '0;
                    end
                end
                LOAD: begin
                    if (ld_valid) begin
                        r_a[w_row_idx] <= a_data;
                        r_b[w_row_idx] <= b_data;
                        r_cnt <= (r_cnt == CW'(N - 1)) ? '0 : r_cnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    if (w_compute_row) begin
                        for (int j = 0; j < N; j++) r_c[w_row_idx][j] <= w_val[j];
                        if (|w_ovf) r_overflow <= 1'b1;
                    end
                    r_cnt <= (r_cnt == CW'(COMPUTE_LAT - 1)) ? '0 : r_cnt + 1'b1;
                    r_row <= '0;
                end
                DRAIN: begin
                    if (w_handshake) begin
                        if (r_row == RW'(N - 1)) begin
                            r_row  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign done     = r_done;
    assign overflow = r_overflow;

    chain_delay_line #(.W(N*DW), .DEPTH(CHAIN_DEPTH)) u_a_chain (
        .clk    (clk),
        .reset  (reset),
        .i_data (a_data_in),
        .o_data (a_data_out)
    );

    chain_delay_line #(.W(N*DW), .DEPTH(CHAIN_DEPTH)) u_b_chain (
        .clk    (clk),
        .reset  (reset),
        .i_data (b_data_in),
        .o_data (b_data_out)
    );

endmodule

// File: tb/tb_tensor_slice_param.sv
// Self-checking bench for tensor_slice_param: table of ops, scoreboard of expected C rows,
// plus hand-written chain and reset-abort sequences.
module tb_tensor_slice_param;

    localparam int N     = 8;
    localparam int DW    = 8;
    localparam int OW    = 16;
    localparam int LAT   = 16;
    localparam int DEPTH = 33;

    logic            clk = 1'b0;
    logic            reset;
    logic            start, accumulate, saturate, ld_valid, c_ready;
    logic [N*DW-1:0] a_data, b_data, a_data_in, b_data_in;
    logic [N*DW-1:0] a_data_out, b_data_out;
    logic            busy, c_valid, c_last, done, overflow;
    logic [N*OW-1:0] c_data_out;

    always #5 clk = ~clk;

    tensor_slice_param #(
        .N(N), .DW(DW), .OW(OW), .COMPUTE_LAT(LAT), .CHAIN_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .accumulate (accumulate),
        .saturate   (saturate),
        .ld_valid   (ld_valid),
        .a_data     (a_data),
        .b_data     (b_data),
        .a_data_in  (a_data_in),
        .b_data_in  (b_data_in),
        .a_data_out (a_data_out),
        .b_data_out (b_data_out),
        .busy       (busy),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .c_data_out (c_data_out),
        .c_last     (c_last),
        .done       (done),
        .overflow   (overflow)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [N*OW-1:0] act, input logic [N*OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // a_kind/b_kind: 0 identity, 1 B[k][j]=k*N+j, 2 all -128, 3 random in [-15,15]
    typedef struct {
        int a_kind;
        int b_kind;
        bit acc;
        bit sat;
        bit bp;          // ld_valid gaps and c_ready toggling
        bit late_start;  // raise start on the final drain handshake
        bit abort_first; // run a partial op and reset it in COMPUTE first
        bit exp_ovf;
    } op_t;

    op_t ops [7];
    int  tA [N][N];
    int  tB [N][N];
    int  model_c [N][N];
    logic [N*OW-1:0] exp_q [$];

    function automatic int gen_elem(input int kind, input int r, input int c);
        case (kind)
            0:       return (r == c) ? 1 : 0;
            1:       return r * N + c;
            2:       return -128;
            default: return int'($urandom_range(0, 30)) - 15;
        endcase
    endfunction

    task automatic build_tiles(input int ak, input int bk);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                tA[i][j] = gen_elem(ak, i, j);
                tB[i][j] = gen_elem(bk, i, j);
            end
    endtask

    // Reference matrix product with OW-bit clamp or truncation; updates the held-C model.
    task automatic push_expected(input bit acc, input bit sat);
        logic [N*OW-1:0] row;
        logic [OW-1:0]   tv;
        int              s;
        for (int i = 0; i < N; i++) begin
            row = '0;
            for (int j = 0; j < N; j++) begin
                s = 0;
                for (int k = 0; k < N; k++) s += tA[i][k] * tB[k][j];
                if (acc) s += model_c[i][j];
                if (sat && s > 32767)       s = 32767;
                else if (sat && s < -32768) s = -32768;
                tv = s[OW-1:0];
                model_c[i][j] = int'($signed(tv));
                row[j*OW +: OW] = tv;
            end
            exp_q.push_back(row);
        end
    endtask

    task automatic drive_beat(input int beat);
        for (int k = 0; k < N; k++) begin
            a_data[k*DW +: DW] = DW'(tA[beat][k]);
            b_data[k*DW +: DW] = DW'(tB[k][beat]);
        end
    endtask

    task automatic abort_op();
        int ndone;
        build_tiles(3, 3);
        @(negedge clk);
        start = 1'b1; accumulate = 1'b0; saturate = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < N; b++) begin
            ld_valid = 1'b1; drive_beat(b);
            @(negedge clk);
        end
        ld_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_in_compute", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_c_valid", c_valid, 0);
        ndone = 0;
        for (int t = 0; t < 40; t++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("abort_no_done", ndone, 0);
        check("abort_idle_after", busy, 0);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) model_c[i][j] = 0;
        $display("op abort: reset applied mid-compute");
    endtask

    task automatic run_op(input int idx);
        op_t o;
        int  cyc, beat, rows, k;
        bit  stalled;
        logic [N*OW-1:0] held, exp_row;
        o = ops[idx];
        if (o.abort_first) abort_op();
        build_tiles(o.a_kind, o.b_kind);
        push_expected(o.acc, o.sat);

        @(negedge clk);
        start = 1'b1; accumulate = o.acc; saturate = o.sat; c_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; accumulate = 1'b0; saturate = 1'b0;
        cyc = 1;
        check("busy_load", busy, 1);
        beat = 0;
        while (beat < N) begin
            if (o.bp && (cyc % 3 == 0)) begin
                ld_valid = 1'b0;
                a_data = '1; b_data = '1;
            end else begin
                ld_valid = 1'b1; drive_beat(beat);
                beat++;
            end
            @(negedge clk);
            cyc++;
        end
        ld_valid = 1'b0;

        k = 0;
        while (!c_valid && k < 200) begin
            @(negedge clk);
            cyc++; k++;
        end
        check("c_valid_seen", c_valid, 1);
        if (!o.bp) check("latency", cyc, 1 + N + LAT);

        rows = 0; k = 0; stalled = 1'b0; held = '0;
        while (rows < N && k < 200) begin
            check("drain_valid", c_valid, 1);
            check("drain_no_done", done, 0);
            if (stalled) check("stall_stable", c_data_out, held);
            c_ready = o.bp ? (k % 2 == 1) : 1'b1;
            if (c_ready) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                    exp_row = '0;
                end else begin
                    exp_row = exp_q.pop_front();
                end
                check($sformatf("op%0d_row%0d", idx, rows), c_data_out, exp_row);
                check("c_last", c_last, (rows == N - 1));
                if (rows == N - 1 && o.late_start) start = 1'b1;
                rows++;
                stalled = 1'b0;
            end else begin
                held = c_data_out;
                stalled = 1'b1;
            end
            @(negedge clk);
            k++;
        end
        check("drain_rows", rows, N);
        c_ready = 1'b0;
        start = 1'b0;
        check("done_pulse", done, 1);
        check("c_valid_low", c_valid, 0);
        check("idle_after", busy, 0);
        check("overflow", overflow, o.exp_ovf);
        @(negedge clk);
        check("done_once", done, 0);
        check("overflow_held", overflow, o.exp_ovf);
        $display("op %0d: acc=%0d sat=%0d bp=%0d rows=%0d overflow=%0d", idx, o.acc, o.sat, o.bp, rows, overflow);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //        a  b  acc sat bp late abort ovf
        ops[0] = '{0, 1, 0, 1, 0, 1, 0, 0};
        ops[1] = '{0, 1, 1, 1, 0, 0, 0, 0};
        ops[2] = '{2, 2, 0, 1, 0, 0, 0, 1};
        ops[3] = '{2, 2, 0, 0, 0, 0, 0, 1};
        ops[4] = '{3, 3, 0, 1, 1, 0, 0, 0};
        ops[5] = '{3, 3, 1, 0, 1, 0, 0, 0};
        ops[6] = '{0, 1, 1, 1, 0, 0, 1, 0};
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) model_c[i][j] = 0;

        reset = 1'b1; start = 1'b0; accumulate = 1'b0; saturate = 1'b0;
        ld_valid = 1'b0; c_ready = 1'b0;
        a_data = '0; b_data = '0; a_data_in = '0; b_data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_c_valid", c_valid, 0);
        check("rst_c_last", c_last, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_c_data", c_data_out, 0);
        check("rst_a_chain", a_data_out, 0);
        check("rst_b_chain", b_data_out, 0);

        for (int i = 0; i < 7; i++) run_op(i);

        // Chain: one-cycle pulse must reappear exactly DEPTH cycles later.
        @(negedge clk);
        a_data_in = {N{8'hA5}};
        b_data_in = {N{8'h5A}};
        @(negedge clk);
        a_data_in = '0; b_data_in = '0;
        for (int t = 1; t <= DEPTH + 6; t++) begin
            check($sformatf("chain_a_t%0d", t), a_data_out, (t == DEPTH) ? {N{8'hA5}} : '0);
            check($sformatf("chain_b_t%0d", t), b_data_out, (t == DEPTH) ? {N{8'h5A}} : '0);
            @(negedge clk);
        end
        $display("chain: pulse checked over %0d cycles", DEPTH + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
